// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 scancode to key event / ASCII decoder with FWFT char FIFO
// Optional macro TYPEMATIC_FILTER_EN suppresses repeated identical make events.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       shift_active,
  output logic       caps_lock,
  input  logic       rd_en,
  output logic [7:0] char_out,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   tmo_cnt;
  logic            evt, evt_ext, evt_brk, fire, repeat_make;
  logic            shift_l, shift_r, caps_held;
  logic [8:0]      map;
  logic            push, pop, wr, drop;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  function automatic logic [8:0] ascii_of(input logic [7:0] code, input logic shift, input logic caps);
    logic [7:0] lc;
    lc = 8'h00;
    ascii_of = 9'h000;
    case (code)
      8'h1C: lc = "a"; 8'h32: lc = "b"; 8'h21: lc = "c"; 8'h23: lc = "d";
      8'h24: lc = "e"; 8'h2B: lc = "f"; 8'h34: lc = "g"; 8'h33: lc = "h";
      8'h43: lc = "i"; 8'h3B: lc = "j"; 8'h42: lc = "k"; 8'h4B: lc = "l";
      8'h3A: lc = "m"; 8'h31: lc = "n"; 8'h44: lc = "o"; 8'h4D: lc = "p";
      8'h15: lc = "q"; 8'h2D: lc = "r"; 8'h1B: lc = "s"; 8'h2C: lc = "t";
      8'h3C: lc = "u"; 8'h2A: lc = "v"; 8'h1D: lc = "w"; 8'h22: lc = "x";
      8'h35: lc = "y"; 8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) begin
      ascii_of = {1'b1, (shift ^ caps) ? lc - 8'h20 : lc};
    end else begin
      case (code)
        8'h16: ascii_of = {1'b1, shift ? "!" : "1"};
        8'h1E: ascii_of = {1'b1, shift ? "@" : "2"};
        8'h26: ascii_of = {1'b1, shift ? "#" : "3"};
        8'h25: ascii_of = {1'b1, shift ? "$" : "4"};
        8'h2E: ascii_of = {1'b1, shift ? "%" : "5"};
        8'h36: ascii_of = {1'b1, shift ? "^" : "6"};
        8'h3D: ascii_of = {1'b1, shift ? "&" : "7"};
        8'h3E: ascii_of = {1'b1, shift ? "*" : "8"};
        8'h46: ascii_of = {1'b1, shift ? "(" : "9"};
        8'h45: ascii_of = {1'b1, shift ? ")" : "0"};
        8'h29: ascii_of = 9'h120;
        8'h5A: ascii_of = 9'h10D;
        8'h66: ascii_of = 9'h108;
        default: ascii_of = 9'h000;
      endcase
    end
  endfunction

  always_comb begin
    state_d = state;
    evt     = 1'b0;
    evt_ext = 1'b0;
    evt_brk = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (code_byte == 8'hE0)      state_d = GOT_E0;
          else if (code_byte == 8'hF0) state_d = GOT_F0;
          else                         evt = 1'b1;
        end
        GOT_E0: begin
          if (code_byte == 8'hF0) state_d = GOT_E0F0;
          else begin
            evt = 1'b1; evt_ext = 1'b1; state_d = IDLE;
          end
        end
        default: begin
          if (code_byte == 8'hE0)      state_d = GOT_E0;
          else if (code_byte == 8'hF0) state_d = state;
          else begin
            evt = 1'b1; evt_brk = 1'b1; evt_ext = (state == GOT_E0F0); state_d = IDLE;
          end
        end
      endcase
    end else if (state != IDLE && tmo_cnt == T_LAST) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_d;
      if (code_valid || state == IDLE || tmo_cnt == T_LAST) tmo_cnt <= '0;
      else                                                   tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [8:0] last_make;
  assign repeat_make = evt && !evt_brk && last_vld && (last_make == {evt_ext, code_byte});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld  <= 1'b0;
      last_make <= '0;
    end else if (evt) begin
      if (!evt_brk) begin
        last_vld  <= 1'b1;
        last_make <= {evt_ext, code_byte};
      end else if (last_make == {evt_ext, code_byte}) begin
        last_vld <= 1'b0;
      end
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  // Character is chosen from the modifier state as it was before this event.
  assign fire         = evt && !repeat_make;
  assign shift_active = shift_l | shift_r;
  assign map          = ascii_of(code_byte, shift_active, caps_lock);
  assign push         = fire && !evt_ext && !evt_brk && map[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else begin
      key_valid <= fire;
      if (fire) begin
        key_code  <= code_byte;
        key_ext   <= evt_ext;
        key_break <= evt_brk;
        if (!evt_ext) begin
          case (code_byte)
            8'h12: shift_l <= !evt_brk;
            8'h59: shift_r <= !evt_brk;
            8'h58: begin
              if (evt_brk) caps_held <= 1'b0;
              else begin
                if (!caps_held) caps_lock <= !caps_lock;
                caps_held <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign pop        = rd_en && !fifo_empty;
  assign wr         = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;
  assign char_out   = fifo_empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= map[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
